// File: rtl/maze_stim_checker_if.sv
// Signal bundle between the maze self-test front end and its environment.
// Carries row configuration, the run start strobe, the serial maze stream to the
// solver, the solver's returned moves, and the grading/status outputs.
//   master : environment side (drives cfg/start/solver moves, observes results)
//   slave  : maze_stim_checker side
interface maze_stim_checker_if #(
    parameter int N = 17
);
    logic         cfg_we;
    logic [4:0]   cfg_row;
    logic [N-1:0] cfg_data;
    logic         start;
    logic         maze_valid;
    logic         maze_bit;
    logic         sol_valid;
    logic [1:0]   sol_dir;
    logic         busy;
    logic         done;
    logic         pass;
    logic [2:0]   err_code;
    logic [9:0]   step_cnt;

    modport master (
        output cfg_we, cfg_row, cfg_data, start, sol_valid, sol_dir,
        input  maze_valid, maze_bit, busy, done, pass, err_code, step_cnt
    );

    modport slave (
        input  cfg_we, cfg_row, cfg_data, start, sol_valid, sol_dir,
        output maze_valid, maze_bit, busy, done, pass, err_code, step_cnt
    );
endinterface

// File: rtl/maze_stim_checker.sv
// Purpose: loads a maze image, serializes it to the solver, then tracks and grades its moves.
// Latency: first maze bit the cycle after start; done one cycle after the grading event.
// Backpressure: none; solver moves must be contiguous and are ignored once a run is graded.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries cfg_we/cfg_row/cfg_data,
// start, maze_valid/maze_bit, sol_valid/sol_dir, busy, done, pass, err_code, step_cnt.
module maze_stim_checker #(
    parameter int N       = 17,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    maze_stim_checker_if.slave    bus
);

    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [4:0]  NX   = 5'(N);
    localparam logic [5:0]  NX6  = 6'(N);
    localparam logic [9:0]  NN   = 10'(N * N);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_TRACK,
        S_REPORT
    } state_t;

    state_t        r_state, w_state_nx;
    logic [N-1:0]  r_maze [N];
    logic [4:0]    r_sx, r_sy, w_sx_nx, w_sy_nx;     // cell currently on maze_bit
    logic [4:0]    r_cx, r_cy, w_cx_nx, w_cy_nx;     // solver cursor
    logic [TW-1:0] r_tmo, w_tmo_nx;
    logic [9:0]    r_step, w_step_nx;
    logic [2:0]    r_err, w_err_nx;
    logic          r_pass, w_pass_nx;
    logic          r_done, w_done_nx;
    logic          r_mvld, w_mvld_nx;
    logic          r_mbit, w_mbit_nx;
    logic          r_busy;

    logic [5:0]    w_nx, w_ny;
    logic          w_oob;
    logic          w_open;
    logic [2:0]    w_mv_err;
    logic [4:0]    w_nsx, w_nsy;

    // The start and goal cells are open by construction, both on the wire and
    // when grading, so an unloaded store still describes a well-formed maze.
    function automatic logic f_open(input logic [4:0] x, input logic [4:0] y);
        logic [N-1:0] row;
        if ((x == 5'd1 && y == 5'd1) || (x == NX && y == NX)) begin
            return 1'b1;
        end
        row = r_maze[x - 5'd1];
        return row[y - 5'd1];
    endfunction

    // Candidate move, computed one bit wider so a step off either edge is visible.
    always_comb begin
        w_nx = {1'b0, r_cx};
        w_ny = {1'b0, r_cy};
        case (bus.sol_dir)
            2'd0:    w_ny = {1'b0, r_cy} + 6'd1;
            2'd1:    w_nx = {1'b0, r_cx} + 6'd1;
            2'd2:    w_ny = {1'b0, r_cy} - 6'd1;
            default: w_nx = {1'b0, r_cx} - 6'd1;
        endcase
        w_oob  = (w_nx == 6'd0) || (w_nx > NX6) || (w_ny == 6'd0) || (w_ny > NX6);
        w_open = !w_oob && f_open(w_nx[4:0], w_ny[4:0]);
        if (w_oob) begin
            w_mv_err = 3'd2;
        end else if (!w_open) begin
            w_mv_err = 3'd1;
        end else if (r_step == NN) begin
            w_mv_err = 3'd5;
        end else begin
            w_mv_err = 3'd0;
        end
    end

    // Next serialized cell: y inner, x outer.
    always_comb begin
        if (r_sy == NX) begin
            w_nsx = r_sx + 5'd1;
            w_nsy = 5'd1;
        end else begin
            w_nsx = r_sx;
            w_nsy = r_sy + 5'd1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sx_nx    = r_sx;
        w_sy_nx    = r_sy;
        w_cx_nx    = r_cx;
        w_cy_nx    = r_cy;
        w_tmo_nx   = r_tmo;
        w_step_nx  = r_step;
        w_err_nx   = r_err;
        w_pass_nx  = r_pass;
        w_done_nx  = 1'b0;
        w_mvld_nx  = 1'b0;
        w_mbit_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_SEND;
                    w_sx_nx    = 5'd1;
                    w_sy_nx    = 5'd1;
                    w_mvld_nx  = 1'b1;
                    w_mbit_nx  = 1'b1;
                    w_pass_nx  = 1'b0;
                    w_err_nx   = 3'd0;
                    w_step_nx  = 10'd0;
                end
            end
            S_SEND: begin
                if (r_sx == NX && r_sy == NX) begin
                    w_state_nx = S_WAIT;
                    w_cx_nx    = 5'd1;
                    w_cy_nx    = 5'd1;
                    w_step_nx  = 10'd0;
                    w_tmo_nx   = '0;
                end else begin
                    w_sx_nx   = w_nsx;
                    w_sy_nx   = w_nsy;
                    w_mvld_nx = 1'b1;
                    w_mbit_nx = f_open(w_nsx, w_nsy);
                end
            end
            S_WAIT, S_TRACK: begin
                if (bus.sol_valid) begin
                    if (w_mv_err != 3'd0) begin
                        w_state_nx = S_REPORT;
                        w_err_nx   = w_mv_err;
                        w_pass_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_TRACK;
                        w_cx_nx    = w_nx[4:0];
                        w_cy_nx    = w_ny[4:0];
                        w_step_nx  = r_step + 10'd1;
                    end
                end else if (r_state == S_TRACK) begin
                    // A gap in the move stream ends the run.
                    w_state_nx = S_REPORT;
                    w_done_nx  = 1'b1;
                    if (r_cx == NX && r_cy == NX) begin
                        w_err_nx  = 3'd0;
                        w_pass_nx = 1'b1;
                    end else begin
                        w_err_nx  = 3'd3;
                        w_pass_nx = 1'b0;
                    end
                end else begin
                    w_tmo_nx = r_tmo + TW'(1);
                    if (w_tmo_nx == TMO) begin
                        w_state_nx = S_REPORT;
                        w_err_nx   = 3'd4;
                        w_pass_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sx    <= 5'd1;
            r_sy    <= 5'd1;
            r_cx    <= 5'd1;
            r_cy    <= 5'd1;
            r_tmo   <= '0;
            r_step  <= 10'd0;
            r_err   <= 3'd0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
            r_mvld  <= 1'b0;
            r_mbit  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sx    <= w_sx_nx;
            r_sy    <= w_sy_nx;
            r_cx    <= w_cx_nx;
            r_cy    <= w_cy_nx;
            r_tmo   <= w_tmo_nx;
            r_step  <= w_step_nx;
            r_err   <= w_err_nx;
            r_pass  <= w_pass_nx;
            r_done  <= w_done_nx;
            r_mvld  <= w_mvld_nx;
            r_mbit  <= w_mbit_nx;
            r_busy  <= (w_state_nx != S_IDLE);
        end
    end

    // Row writes land at the same edge that samples start, so a run started
    // together with a write already sees the new row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_maze[i] <= '0;
            end
        end else if (r_state == S_IDLE && bus.cfg_we &&
                     bus.cfg_row >= 5'd1 && bus.cfg_row <= NX) begin
            r_maze[bus.cfg_row - 5'd1] <= bus.cfg_data;
        end
    end

    assign bus.maze_valid = r_mvld;
    assign bus.maze_bit   = r_mbit;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_code   = r_err;
    assign bus.step_cnt   = r_step;

endmodule
